// File: rtl/angle_track_pkg.sv
// angle_track_pkg: settle FSM encoding, settle counter width and half-turn helper
package angle_track_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEEK = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int SETTLE_W = 4;

  function automatic int half_turn(input int w);
    return 1 << (w - 1);
  endfunction
endpackage

// File: rtl/angle_track_ch.sv
// angle_track_ch: one encoder channel (sync, capture, shortest-path error, settle FSM); watchdog under ANGLE_TRACK_STALE_EN
module angle_track_ch
  import angle_track_pkg::*;
#(
  parameter int ANGLE_W = 12,
  parameter int SETTLE  = 3,
  parameter int STALE_W = 20
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               rd_done,
  input  logic [ANGLE_W-1:0] raw_angle,
  input  logic [ANGLE_W-1:0] target_angle,
  input  logic               angle_update,
  input  logic               abort,
  input  logic [ANGLE_W-1:0] tolerance,
  input  logic [STALE_W-1:0] stale_limit,
  output logic [ANGLE_W-1:0] current_angle,
  output logic [ANGLE_W-1:0] angle_error,
  output logic               direction,
  output logic               angle_done,
  output logic               stale
);
  localparam logic [ANGLE_W-1:0] HALF = ANGLE_W'(half_turn(ANGLE_W));

  logic                sync1_q, sync1_d, sync2_q, sync2_d;
  logic                smp_q, smp_d, upd_q, upd_d, dir_q, dir_d;
  logic [1:0]          eval_q, eval_d;
  logic [ANGLE_W-1:0]  cur_q, cur_d, tgt_q, tgt_d, err_q, err_d, diff;
  logic [SETTLE_W-1:0] cnt_q, cnt_d, cnt_inc;
  state_t              state_q, state_d;
  logic                take_upd, in_tol;

  // Datapath: rd_done edge detect, capture, target latch and wrap-aware error
  always_comb begin
    take_upd = angle_update & ~abort;
    sync1_d  = rd_done;
    sync2_d  = sync1_q;
    smp_d    = sync1_q & ~sync2_q;
    cur_d    = smp_q ? raw_angle : cur_q;
    tgt_d    = take_upd ? target_angle : tgt_q;
    upd_d    = smp_q | take_upd;
    diff     = tgt_q - cur_q;
    err_d    = upd_q ? ((diff > HALF) ? ANGLE_W'(0) - diff : diff) : err_q;
    dir_d    = upd_q ? (diff <= HALF) : dir_q;
    eval_d   = (angle_update | abort) ? 2'b00 : {eval_q[0], smp_q};
    in_tol   = err_q <= tolerance;
  end

  // Settle FSM: abort beats update beats eval; an eval pending across an update is dropped
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + 1'b1;
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (angle_update) begin
      state_d = ST_SEEK;
      cnt_d   = '0;
    end else if (eval_q[1]) begin
      case (state_q)
        ST_SEEK: begin
          cnt_d = in_tol ? cnt_inc : '0;
          if (in_tol && int'(cnt_inc) >= SETTLE) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end
        end
        ST_DONE: state_d = in_tol ? ST_DONE : ST_SEEK;
        default: state_d = state_q;
      endcase
    end
  end

  // Channel state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      smp_q   <= 1'b0;
      upd_q   <= 1'b0;
      dir_q   <= 1'b0;
      eval_q  <= '0;
      cur_q   <= '0;
      tgt_q   <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
      state_q <= ST_IDLE;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      smp_q   <= smp_d;
      upd_q   <= upd_d;
      dir_q   <= dir_d;
      eval_q  <= eval_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign current_angle = cur_q;
  assign angle_error   = err_q;
  assign direction     = dir_q;
  assign angle_done    = state_q == ST_DONE;

`ifdef ANGLE_TRACK_STALE_EN
  logic [STALE_W-1:0] wd_q, wd_d;

  // Watchdog: clears on each sample, otherwise counts up and saturates
  always_comb wd_d = smp_q ? '0 : ((&wd_q) ? wd_q : wd_q + 1'b1);

  // Watchdog counter register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) wd_q <= '0;
    else          wd_q <= wd_d;
  end

  assign stale = (stale_limit != '0) && (wd_q >= stale_limit);
`else
  logic unused_stale_limit;
  assign unused_stale_limit = ^stale_limit;
  assign stale = 1'b0;
`endif
endmodule

// File: rtl/angle_track_mc.sv
// angle_track_mc: sensor clock divider plus NUM_CH angle tracking channels (watchdog under ANGLE_TRACK_STALE_EN)
module angle_track_mc
  import angle_track_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int ANGLE_W      = 12,
  parameter int CLK_DIV_LOG2 = 7,
  parameter int SETTLE       = 3,
  parameter int STALE_W      = 20
) (
  input  logic                      clock,
  input  logic                      reset_n,
  output logic                      sensor_clk,
  input  logic [NUM_CH-1:0]         rd_done,
  input  logic [NUM_CH*ANGLE_W-1:0] raw_angle,
  input  logic [NUM_CH*ANGLE_W-1:0] target_angle,
  input  logic [NUM_CH-1:0]         angle_update,
  input  logic [NUM_CH-1:0]         abort,
  input  logic [ANGLE_W-1:0]        tolerance,
  input  logic [STALE_W-1:0]        stale_limit,
  output logic [NUM_CH*ANGLE_W-1:0] current_angle,
  output logic [NUM_CH*ANGLE_W-1:0] angle_error,
  output logic [NUM_CH-1:0]         direction,
  output logic [NUM_CH-1:0]         angle_done,
  output logic [NUM_CH-1:0]         stale
);
  logic [CLK_DIV_LOG2-1:0] div_q, div_d;

  // Free-running divider; its MSB is the shared reader clock
  always_comb div_d = div_q + 1'b1;

  // Divider register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) div_q <= '0;
    else          div_q <= div_d;
  end

  assign sensor_clk = div_q[CLK_DIV_LOG2-1];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    angle_track_ch #(
      .ANGLE_W(ANGLE_W),
      .SETTLE (SETTLE),
      .STALE_W(STALE_W)
    ) u_ch (
      .clock        (clock),
      .reset_n      (reset_n),
      .rd_done      (rd_done[g]),
      .raw_angle    (raw_angle[g*ANGLE_W +: ANGLE_W]),
      .target_angle (target_angle[g*ANGLE_W +: ANGLE_W]),
      .angle_update (angle_update[g]),
      .abort        (abort[g]),
      .tolerance    (tolerance),
      .stale_limit  (stale_limit),
      .current_angle(current_angle[g*ANGLE_W +: ANGLE_W]),
      .angle_error  (angle_error[g*ANGLE_W +: ANGLE_W]),
      .direction    (direction[g]),
      .angle_done   (angle_done[g]),
      .stale        (stale[g])
    );
  end
endmodule
